vc_pop_arbiter: RTL and testbench
=================================

# vc_pop_arbiter

Round-robin read arbiter between the per-channel FIFOs and the shared downstream stage of the transaction path. It consumes the `can_pop` status of each channel's flow-control block and the `pause` of the downstream flow-control block. It issues one-cycle read strobes to at most one FIFO at a time and forwards the read word with a valid strobe and channel tag. A two-state-per-word FSM keeps the FIFO status flags fresh before each new decision, so an emptied FIFO is never popped twice.

## Interface
- `BITNUMBER`, 6, data word width.
- `NUM_FIFOS`, 4, number of source FIFOs/channels. Legal values: 2..8.
- `ID_W`, 2, width of channel tag; must satisfy 2^ID_W >= NUM_FIFOS.

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `can_pop`  in  NUM_FIFOS  per-channel "FIFO non-empty" from the upstream flow-control blocks.
- `pause`  in  1  downstream full; blocks new grants.
- `fifo_data_in`  in  NUM_FIFOS*BITNUMBER  concatenated FIFO read data; channel i occupies bits [i*BITNUMBER +: BITNUMBER]. Valid one cycle after that FIFO's `pop`.
- `pop`  out  NUM_FIFOS  one-hot read strobe to the FIFOs (`Fifo_rd`); registered.
- `data_out`  out  BITNUMBER  forwarded word; registered.
- `valid_out`  out  1  `data_out` valid, one-cycle pulse.
- `grant_id`  out  ID_W  channel of the current `data_out`; holds its value between pulses.

## Operation
- FSM states:
  - IDLE: no grant outstanding.
  - POP: `pop[g]` is high this cycle.
  - WAIT: FIFO g drives read data.
- Eligibility: `elig = can_pop & {NUM_FIFOS{~pause}}`, evaluated only in IDLE and WAIT.
- Selection:
  - Round-robin pointer `last` holds the last granted channel.
  - The search starts at `(last+1) mod NUM_FIFOS` and wraps; the first eligible channel wins.
  - When the pointer is at `NUM_FIFOS-1`, the search begins at 0.
- Transitions:
  - IDLE → POP when `elig != 0`; otherwise stay in IDLE.
  - POP → WAIT unconditionally.
  - WAIT → POP when `elig != 0` (back-to-back); otherwise WAIT → IDLE.
- On entry to POP: `g` latched, `last <= g`, `pop <= onehot(g)`. In every other state `pop = 0`.
- On WAIT exit:
  - `data_out <= fifo_data_in[g]`
  - `grant_id <= g`
  - `valid_out <= 1`
  - Otherwise `valid_out <= 0`.
- `pause` rising while in POP or WAIT does not cancel the outstanding word; it completes and `valid_out` still pulses. `pause` only prevents the next grant.
- `can_pop` falling for the granted channel during POP or WAIT has no effect on the outstanding word.
- Reset values:
  - state = IDLE, `pop` = 0, `valid_out` = 0.
  - `data_out` = 0, `grant_id` = 0.
  - `last = NUM_FIFOS-1`, so the first grant after reset goes to the lowest eligible channel.
- Reset mid-transaction: the outstanding word is dropped; no `valid_out` is produced for it.

## Timing
- Decision is made in cycle N-1 (IDLE or WAIT); `pop[g]` is high in cycle N.
- FIFO data is present in N+1; `data_out`/`valid_out` are high in N+2.
- Pop-to-valid latency is 2 cycles.
- Maximum throughput is one word per 2 cycles (`pop` pulses at N, N+2, N+4, …).
- `can_pop` sampled in WAIT already reflects the pop issued at N (FIFO flags update at the edge ending N).
- No combinational path from any input to any output.

## Structure
- Package `vc_arb_pkg`:
  - state encoding localparams (IDLE=2'd0, POP=2'd1, WAIT=2'd2).
  - default `NUM_FIFOS` / `ID_W` constants.
  - `onehot` function.
- Sub-module `rr_pick`: combinational, parameterised round-robin priority finder.
  - Inputs: `req[NUM_FIFOS]`, `last[ID_W]`.
  - Outputs: `gnt_id`, `any`.
  - Implemented by doubling the request vector and using a fixed-priority search.

## Test plan
- Reset, then `can_pop=4'b0001`, `pause=0` → `pop=0001` in the first cycle after the IDLE decision. `valid_out` pulses 2 cycles later with `data_out` = channel 0 word and `grant_id=0`.
- `can_pop=4'b1111` held, `pause=0` → `pop` sequence 0001, 0010, 0100, 1000, 0001 with a one-cycle gap between pulses. `grant_id` follows 0,1,2,3,0.
- `can_pop=4'b1010` → grants alternate 1,3,1,3. Channels 0 and 2 are never popped.
- `pause=1` asserted in the same cycle `pop[2]` is high → `valid_out` still pulses with channel 2 data. No further `pop` occurs while `pause=1`; popping resumes at the next channel (3) after `pause` falls.
- Channel 1 holds exactly one word (its `can_pop` drops the cycle after its pop) and all other channels are empty → exactly one `pop[1]` pulse and FSM returns to IDLE. No second read.
- `reset` asserted in the WAIT cycle → no `valid_out` pulse. All outputs are 0 the next cycle; the first grant after release goes to the lowest eligible channel.

Source files
------------

// File: rtl/vc_pop_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// vc_arb_pkg : shared constants, state encoding and helpers for vc_pop_arbiter
// Rev 1.0
// ============================================================================
package vc_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int BITNUMBER_DEF = 6;
    localparam int NUM_FIFOS_DEF = 4;
    localparam int ID_W_DEF      = 2;
    localparam int MAX_FIFOS     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_POP  = POP,
        ST_WAIT = WAIT
    } state_t;

    function automatic logic [MAX_FIFOS-1:0] onehot(input logic [2:0] idx);
        return MAX_FIFOS'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_pop_arbiter_if.sv
`default_nettype none
// ============================================================================
// vc_pop_arbiter_if : FIFO-side and downstream-side signals of the read arbiter
// Rev 1.0
// ============================================================================
interface vc_pop_arbiter_if
    import vc_arb_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int ID_W      = ID_W_DEF
);
    logic [NUM_FIFOS-1:0]           can_pop;
    logic                           pause;
    logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data_in;
    logic [NUM_FIFOS-1:0]           pop;
    logic [BITNUMBER-1:0]           data_out;
    logic                           valid_out;
    logic [ID_W-1:0]                grant_id;

    modport master (
        input  can_pop, pause, fifo_data_in,
        output pop, data_out, valid_out, grant_id
    );

    modport slave (
        output can_pop, pause, fifo_data_in,
        input  pop, data_out, valid_out, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/vc_pop_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : round-robin priority finder over a doubled request vector
// Rev 1.0
// ============================================================================
module rr_pick
    import vc_arb_pkg::*;
#(
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  wire logic [NUM_FIFOS-1:0] req,
    input  wire logic [ID_W-1:0]      last,
    output logic      [ID_W-1:0]      gnt_id,
    output logic                      any
);
    logic [2*NUM_FIFOS-1:0] w_req2;
    logic [ID_W-1:0]        w_start;

    assign w_req2  = {req, req};
    assign w_start = (int'(last) >= NUM_FIFOS - 1) ? '0 : last + 1'b1;

    // Scan high-to-low so the lowest index inside the window is the last writer.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 2*NUM_FIFOS - 1; i >= 0; i--) begin
            if (i >= int'(w_start) && i < int'(w_start) + NUM_FIFOS && w_req2[i]) begin
                gnt_id = ID_W'(i % NUM_FIFOS);
                any    = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// vc_pop_arbiter : round-robin read arbiter from per-channel FIFOs to one stage
// Rev 1.0
// ============================================================================
module vc_pop_arbiter
    import vc_arb_pkg::*;
#(
    parameter int BITNUMBER = BITNUMBER_DEF,
    parameter int NUM_FIFOS = NUM_FIFOS_DEF,
    parameter int ID_W      = ID_W_DEF
) (
    input  wire logic       clk,
    input  wire logic       reset,
    vc_pop_arbiter_if.master bus
);
    state_t               r_state, w_state_nxt;
    logic [NUM_FIFOS-1:0] r_pop, w_pop_nxt;
    logic [ID_W-1:0]      r_g, w_g_nxt;
    logic [ID_W-1:0]      r_last, w_last_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [BITNUMBER-1:0] r_data, w_data_nxt;
    logic [ID_W-1:0]      r_gid, w_gid_nxt;

    logic [NUM_FIFOS-1:0] w_elig;
    logic [ID_W-1:0]      w_pick;
    logic                 w_any;

    assign w_elig = bus.can_pop & {NUM_FIFOS{~bus.pause}};

    rr_pick #(
        .NUM_FIFOS (NUM_FIFOS),
        .ID_W      (ID_W)
    ) u_rr_pick (
        .req    (w_elig),
        .last   (r_last),
        .gnt_id (w_pick),
        .any    (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop_nxt   = '0;
        w_g_nxt     = r_g;
        w_last_nxt  = r_last;
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data;
        w_gid_nxt   = r_gid;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_POP;
                    w_pop_nxt   = NUM_FIFOS'(onehot(3'(w_pick)));
                    w_g_nxt     = w_pick;
                    w_last_nxt  = w_pick;
                end
            end
            ST_POP: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // The outstanding word always completes; eligibility only gates the next grant.
                w_valid_nxt = 1'b1;
                w_data_nxt  = bus.fifo_data_in[int'(r_g)*BITNUMBER +: BITNUMBER];
                w_gid_nxt   = r_g;
                if (w_any) begin
                    w_state_nxt = ST_POP;
                    w_pop_nxt   = NUM_FIFOS'(onehot(3'(w_pick)));
                    w_g_nxt     = w_pick;
                    w_last_nxt  = w_pick;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pop   <= '0;
            r_g     <= '0;
            r_last  <= ID_W'(NUM_FIFOS - 1);
            r_valid <= 1'b0;
            r_data  <= '0;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pop   <= w_pop_nxt;
            r_g     <= w_g_nxt;
            r_last  <= w_last_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_gid   <= w_gid_nxt;
        end
    end

    assign bus.pop       = r_pop;
    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_data;
    assign bus.grant_id  = r_gid;
endmodule
`default_nettype wire

// File: tb/tb_vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vc_pop_arbiter : directed bench with FIFO model and expected-word scoreboard
// Rev 1.0
// ============================================================================
module tb_vc_pop_arbiter;
    import vc_arb_pkg::*;

    localparam int BW = 6;
    localparam int NF = 4;
    localparam int IW = 2;

    typedef struct {
        int             id;
        logic [BW-1:0]  data;
        int             due;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vc_pop_arbiter_if #(.BITNUMBER(BW), .NUM_FIFOS(NF), .ID_W(IW)) bus ();

    vc_pop_arbiter #(.BITNUMBER(BW), .NUM_FIFOS(NF), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int avail  [NF];
    int rd_cnt [NF];
    logic [NF-1:0] prev_pop = '0;
    int exp_gnt[$];
    sb_t sb[$];
    int last_pop_ch  = -1;
    int last_pop_cyc = -1;
    int prev_pop_cyc = -1;
    bit spacing_on   = 1'b0;

    function automatic logic [BW-1:0] word_of(int ch, int k);
        return BW'(ch*13 + k*5 + 7);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NF; i++) bus.can_pop[i] = (avail[i] > 0);
    endtask

    // One clock: FIFO model reacts to last cycle's pop, then outputs are scored.
    task automatic tick();
        sb_t item;
        int  e;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NF; i++) begin
            if (prev_pop[i]) begin
                bus.fifo_data_in[i*BW +: BW] = word_of(i, rd_cnt[i]);
                rd_cnt[i]++;
                if (avail[i] > 0) avail[i]--;
            end
        end
        refresh();
        if (bus.pop !== '0) begin
            if (spacing_on && prev_pop_cyc >= 0) chk("pop_spacing", 32'(cyc - prev_pop_cyc), 32'd2);
            prev_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_gnt.size() == 0) begin
                chk("unexpected_pop", 32'(bus.pop), 32'd0);
            end else begin
                e = exp_gnt.pop_front();
                chk("pop_onehot", 32'(bus.pop), 32'd1 << e);
                sb.push_back('{e, word_of(e, rd_cnt[e]), cyc + 2});
                last_pop_ch = e;
            end
        end
        if (bus.valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                item = sb.pop_front();
                chk("data_out", 32'(bus.data_out), 32'(item.data));
                chk("grant_id", 32'(bus.grant_id), 32'(item.id));
                chk("valid_latency", 32'(cyc), 32'(item.due));
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missing_valid", 32'd0, 32'd1);
            sb.delete(0);
        end
        prev_pop = bus.pop;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic drained(string tag);
        chk({tag, "_grants_left"}, 32'(exp_gnt.size()), 32'd0);
        chk({tag, "_words_left"},  32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.pause = 1'b0;
        for (int i = 0; i < NF; i++) avail[i] = 0;
        exp_gnt.delete();
        sb.delete();
        refresh();
        run(2);
        chk("rst_pop",       32'(bus.pop),       32'd0);
        chk("rst_valid",     32'(bus.valid_out), 32'd0);
        chk("rst_data",      32'(bus.data_out),  32'd0);
        chk("rst_grant_id",  32'(bus.grant_id),  32'd0);
        prev_pop     = '0;
        last_pop_ch  = -1;
        last_pop_cyc = -1;
        prev_pop_cyc = -1;
        spacing_on   = 1'b0;
        reset        = 1'b0;
    endtask

    initial begin
        bus.pause        = 1'b0;
        bus.can_pop      = '0;
        bus.fifo_data_in = '0;
        for (int i = 0; i < NF; i++) rd_cnt[i] = 0;

        // Single channel 0 word after reset.
        do_reset();
        avail[0] = 1; refresh();
        exp_gnt.push_back(0);
        run(8);
        drained("single_ch0");

        // All channels eligible: full rotation and wrap back to 0, back-to-back.
        do_reset();
        avail[0] = 2; avail[1] = 1; avail[2] = 1; avail[3] = 1; refresh();
        spacing_on = 1'b1;
        foreach (exp_gnt[i]) ;
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        run(16);
        drained("rotate");

        // Channels 1 and 3 only alternate.
        do_reset();
        avail[1] = 2; avail[3] = 2; refresh();
        spacing_on = 1'b1;
        exp_gnt.push_back(1); exp_gnt.push_back(3);
        exp_gnt.push_back(1); exp_gnt.push_back(3);
        run(14);
        drained("alt_1_3");

        // Pause raised while pop[2] is high: word completes, no new grants until release.
        do_reset();
        for (int i = 0; i < NF; i++) avail[i] = 5;
        refresh();
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_pop_ch == 2 && last_pop_cyc == cyc) break;
        end
        chk("pause_reached_ch2", 32'(last_pop_ch), 32'd2);
        bus.pause = 1'b1;
        run(8);
        drained("paused");
        for (int i = 0; i < NF; i++) avail[i] = 1;
        refresh();
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        exp_gnt.push_back(1); exp_gnt.push_back(2);
        bus.pause = 1'b0;
        run(14);
        drained("resume");

        // Channel 1 holds exactly one word: one read, no second pop.
        do_reset();
        avail[1] = 1; refresh();
        exp_gnt.push_back(1);
        run(10);
        drained("one_word");

        // Reset during WAIT drops the outstanding word; next grant is the lowest eligible.
        do_reset();
        avail[1] = 3; avail[3] = 3; refresh();
        exp_gnt.push_back(1);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_pop_cyc == cyc) break;
        end
        chk("midrst_popped", 32'(last_pop_cyc), 32'(cyc));
        tick();
        reset = 1'b1;
        sb.delete();
        tick();
        chk("midrst_valid",    32'(bus.valid_out), 32'd0);
        chk("midrst_pop",      32'(bus.pop),       32'd0);
        chk("midrst_data",     32'(bus.data_out),  32'd0);
        chk("midrst_grant_id", 32'(bus.grant_id),  32'd0);
        for (int i = 0; i < NF; i++) avail[i] = 0;
        avail[1] = 1; avail[3] = 1; refresh();
        prev_pop = '0;
        exp_gnt.delete();
        exp_gnt.push_back(1); exp_gnt.push_back(3);
        reset = 1'b0;
        run(10);
        drained("after_midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
